mem_rd_arbiter: RTL and testbench

- Shares the single SimRAM read port between two requesters: core instruction fetch and a data/debug read requester.
- Sits between the core/debug logic and the RAM.
- Per cycle: grants at most one request, drives the RAM read port, and routes each in-order RAM response back to the requester that issued it.
- Tracks responses with an owner-tag FIFO, so RAM read latency need not be fixed.

---
 rtl/mem_rd_arb_pkg.sv | 20 ++
 rtl/mem_rd_arb_tag_fifo.sv | 56 +++++
 rtl/mem_rd_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_rd_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rd_arb_pkg.sv
// Shared types and helpers for the SimRAM read-port arbiter.
// Owner tags identify which requester a RAM read belongs to.
package mem_rd_arb_pkg;

  typedef enum logic [0:0] {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  // Ceiling log2. Returns 0 for an argument of 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_rd_arb_tag_fifo.sv
// Owner-tag FIFO: one entry per RAM read in flight, popped in RAM response order.
// A push and a pop in the same cycle are both accepted, even when the FIFO is full.
module mem_rd_arb_tag_fifo
  import mem_rd_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  owner_e push_owner,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output owner_e head
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  owner_e             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Tag storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_owner;
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Two-requester arbiter for the single SimRAM read port, with in-order response routing.
// Optional performance counters are built when MEM_RD_ARB_PERF_CNT_EN is defined.
module mem_rd_arbiter
  import mem_rd_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-3:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rsp_valid,
  output logic [DATA_WIDTH-1:0] f_rsp_data,
  output logic [ADDR_WIDTH-3:0] f_rsp_addr,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-3:0] d_addr,
  output logic                  d_gnt,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic [ADDR_WIDTH-3:0] d_rsp_addr,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-3:0] ram_rd_addr,
  input  logic                  ram_rd_valid,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  input  logic [ADDR_WIDTH-3:0] ram_rd_addr_out,
  output logic                  err_orphan
`ifdef MEM_RD_ARB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_f_grants,
  output logic [31:0]           perf_d_grants,
  output logic [31:0]           perf_full_stalls
`endif
);

  localparam int SC_W = clog2(STARVE_LIMIT + 1);

  logic             fifo_full;
  logic             fifo_empty;
  owner_e           head_owner;
  owner_e           push_owner;
  logic             grant_f;
  logic             grant_d;
  logic             fetch_prio;
  logic             rsp_fire;
  logic [SC_W-1:0]  starve_cnt;

  // Handshake: a requester holds req and addr until its gnt is seen high in the
  // same cycle; gnt, ram_rd_en and ram_rd_addr are combinational from req and
  // registered state only, never from ram_rd_valid.
  assign fetch_prio = (starve_cnt == SC_W'(STARVE_LIMIT));

  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (!rst && !fifo_full) begin
      if (f_req && d_req) begin
        if (fetch_prio) grant_f = 1'b1;
        else            grant_d = 1'b1;
      end else if (f_req) begin
        grant_f = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  assign f_gnt      = grant_f;
  assign d_gnt      = grant_d;
  assign ram_rd_en  = grant_f || grant_d;
  assign push_owner = grant_d ? OWNER_DATA : OWNER_FETCH;

  always_comb begin
    ram_rd_addr = '0;
    if (grant_f)      ram_rd_addr = f_addr;
    else if (grant_d) ram_rd_addr = d_addr;
  end

  // Counts consecutive cycles fetch was left waiting; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!f_req || grant_f) begin
      starve_cnt <= '0;
    end else if (!fetch_prio) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  mem_rd_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (ram_rd_en),
    .push_owner (push_owner),
    .pop        (rsp_fire),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head_owner)
  );

  // The head tag steers each response; data and address fan out unqualified.
  assign rsp_fire    = ram_rd_valid && !fifo_empty && !rst;
  assign f_rsp_valid = rsp_fire && (head_owner == OWNER_FETCH);
  assign d_rsp_valid = rsp_fire && (head_owner == OWNER_DATA);
  assign f_rsp_data  = ram_rd_data;
  assign d_rsp_data  = ram_rd_data;
  assign f_rsp_addr  = ram_rd_addr_out;
  assign d_rsp_addr  = ram_rd_addr_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_orphan <= 1'b0;
    end else if (ram_rd_valid && fifo_empty) begin
      err_orphan <= 1'b1;
    end
  end

`ifdef MEM_RD_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_f_grants    <= '0;
      perf_d_grants    <= '0;
      perf_full_stalls <= '0;
    end else begin
      if (grant_f) perf_f_grants <= perf_f_grants + 32'd1;
      if (grant_d) perf_d_grants <= perf_d_grants + 32'd1;
      if ((f_req || d_req) && fifo_full) perf_full_stalls <= perf_full_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter with a RAM model and a response scoreboard.
// Builds the perf-counter checks when MEM_RD_ARB_PERF_CNT_EN is defined.
module tb_mem_rd_arbiter;
  import mem_rd_arb_pkg::*;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int W  = 1 + AW + DW;

  logic          clk;
  logic          rst;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rsp_valid;
  logic [DW-1:0] f_rsp_data;
  logic [AW-1:0] f_rsp_addr;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic          d_gnt;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rsp_data;
  logic [AW-1:0] d_rsp_addr;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic          ram_rd_valid;
  logic [DW-1:0] ram_rd_data;
  logic [AW-1:0] ram_rd_addr_out;
  logic          err_orphan;
`ifdef MEM_RD_ARB_PERF_CNT_EN
  logic [31:0]   perf_f_grants;
  logic [31:0]   perf_d_grants;
  logic [31:0]   perf_full_stalls;
`endif

  // Scoreboard entry: {owner_is_data, addr, data}
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] ram_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic          s_fg, s_dg, s_en, s_frv, s_drv;

  mem_rd_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .f_req           (f_req),
    .f_addr          (f_addr),
    .f_gnt           (f_gnt),
    .f_rsp_valid     (f_rsp_valid),
    .f_rsp_data      (f_rsp_data),
    .f_rsp_addr      (f_rsp_addr),
    .d_req           (d_req),
    .d_addr          (d_addr),
    .d_gnt           (d_gnt),
    .d_rsp_valid     (d_rsp_valid),
    .d_rsp_data      (d_rsp_data),
    .d_rsp_addr      (d_rsp_addr),
    .ram_rd_en       (ram_rd_en),
    .ram_rd_addr     (ram_rd_addr),
    .ram_rd_valid    (ram_rd_valid),
    .ram_rd_data     (ram_rd_data),
    .ram_rd_addr_out (ram_rd_addr_out),
    .err_orphan      (err_orphan)
`ifdef MEM_RD_ARB_PERF_CNT_EN
    ,
    .perf_f_grants    (perf_f_grants),
    .perf_d_grants    (perf_d_grants),
    .perf_full_stalls (perf_full_stalls)
`endif
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Samples outputs mid-cycle, records grants, and scores responses.
  task automatic observe();
    logic [W-1:0]  e;
    logic [AW-1:0] a;
    s_fg  = f_gnt;
    s_dg  = d_gnt;
    s_en  = ram_rd_en;
    s_frv = f_rsp_valid;
    s_drv = d_rsp_valid;
    if (f_gnt || d_gnt) begin
      a = f_gnt ? f_addr : d_addr;
      check("one_grant", 64'(f_gnt & d_gnt), 64'(0));
      check("rd_en", 64'(ram_rd_en), 64'(1));
      check("rd_addr", 64'(ram_rd_addr), 64'(a));
      exp_q.push_back({d_gnt, a, DW'(a)});
      ram_q.push_back(ram_rd_addr);
    end else begin
      check("idle_port", 64'({ram_rd_en, ram_rd_addr}), 64'(0));
    end
    if (f_rsp_valid || d_rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'({f_rsp_valid, d_rsp_valid}), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("rsp_owner", 64'({f_rsp_valid, d_rsp_valid}), e[W-1] ? 64'(2'b01) : 64'(2'b10));
        check("rsp_addr", 64'(f_rsp_valid ? f_rsp_addr : d_rsp_addr), 64'(e[W-2:DW]));
        check("rsp_data", 64'(f_rsp_valid ? f_rsp_data : d_rsp_data), 64'(e[DW-1:0]));
      end
    end
  endtask

  // One cycle: RAM model drives a response (if asked), outputs are sampled, clock advances.
  task automatic tick(input bit ret);
    logic [AW-1:0] a;
    ram_rd_valid    = 1'b0;
    ram_rd_addr_out = '0;
    ram_rd_data     = '0;
    if (ret && ram_q.size() > 0) begin
      a = ram_q.pop_front();
      ram_rd_valid    = 1'b1;
      ram_rd_addr_out = a;
      ram_rd_data     = DW'(a);
    end
    #1;
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string tag);
    check(tag, 64'({exp_q.size() == 0, ram_q.size() == 0}), 64'(2'b11));
  endtask

  initial begin
    bit            exp_fetch;
    int            dn;
    logic [1:0]    il_pat [4];
    rst = 1'b1; f_req = 1'b1; d_req = 1'b1;
    f_addr = AW'(32'h11); d_addr = AW'(32'h22);
    ram_rd_valid = 1'b0; ram_rd_data = '0; ram_rd_addr_out = '0;
    @(posedge clk);
    #1;

    // Reset: requests held high must not be granted
    repeat (2) begin
      tick(0);
      check("rst_no_gnt", 64'({s_fg, s_dg, s_en}), 64'(0));
    end
    exp_q.delete();
    ram_q.delete();
    rst = 1'b0; f_req = 1'b0; d_req = 1'b0;
    tick(0);
    check("rst_idle_rsp", 64'({s_frv, s_drv}), 64'(0));
    check("rst_err", 64'(err_orphan), 64'(0));

    // Fetch-only, RAM latency 1
    for (int i = 0; i < 6; i++) begin
      f_req = 1'b1; f_addr = AW'(32'h100 + i);
      tick(1);
      check("fo_gnt", 64'({s_fg, s_dg}), 64'(2'b10));
      check("fo_rsp_timing", 64'(s_frv), 64'(i > 0));
      check("fo_no_drsp", 64'(s_drv), 64'(0));
    end
    f_req = 1'b0;
    tick(1);
    check("fo_last_rsp", 64'(s_frv), 64'(1));
    check_drained("fo_drained");

    // Contention: 8 data grants then 1 fetch grant
    dn = 0;
    for (int i = 0; i < 18; i++) begin
      f_req = 1'b1; f_addr = AW'(32'h200);
      d_req = 1'b1; d_addr = AW'(32'h300 + dn);
      tick(1);
      if (s_dg) dn++;
      exp_fetch = ((i % 9) == 8);
      check("ct_gnt", 64'({s_fg, s_dg}), exp_fetch ? 64'(2'b10) : 64'(2'b01));
      if (exp_fetch) check("ct_starve_clr", 64'(dut.starve_cnt), 64'(0));
      else           check("ct_starve_inc", 64'(dut.starve_cnt), 64'((i % 9) + 1));
    end
    f_req = 1'b0; d_req = 1'b0;
    tick(1);
    check_drained("ct_drained");

    // Backpressure: RAM silent, 4 grants then stall
    d_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d_addr = AW'(32'h400 + ((i < 4) ? i : 4));
      tick(0);
      check("bp_gnt", 64'(s_dg), 64'(i < 4));
      check("bp_en", 64'(s_en), 64'(i < 4));
    end
    tick(1);
    check("bp_pop_no_gnt", 64'({s_dg, s_en, s_drv}), 64'(3'b001));
    tick(0);
    check("bp_gnt_after_pop", 64'(s_dg), 64'(1));
    d_req = 1'b0;
    repeat (5) tick(1);
    check_drained("bp_drained");

    // Interleaved routing: D,F,F,D
    d_req = 1'b1; d_addr = AW'(32'h10);
    tick(0);
    check("il_g0", 64'({s_fg, s_dg}), 64'(2'b01));
    d_req = 1'b0; f_req = 1'b1; f_addr = AW'(32'h20);
    tick(0);
    check("il_g1", 64'({s_fg, s_dg}), 64'(2'b10));
    f_addr = AW'(32'h24);
    tick(0);
    check("il_g2", 64'({s_fg, s_dg}), 64'(2'b10));
    f_req = 1'b0; d_req = 1'b1; d_addr = AW'(32'h14);
    tick(0);
    check("il_g3", 64'({s_fg, s_dg}), 64'(2'b01));
    d_req = 1'b0;
    il_pat[0] = 2'b01; il_pat[1] = 2'b10; il_pat[2] = 2'b10; il_pat[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("il_rsp_route", 64'({s_frv, s_drv}), 64'(il_pat[i]));
    end
    check_drained("il_drained");

    // Orphans: 3 reads in flight, one returns during reset, two after
    d_req = 1'b1; d_addr = AW'(32'h40);
    tick(0);
    d_req = 1'b0; f_req = 1'b1; f_addr = AW'(32'h44);
    tick(0);
    f_req = 1'b0; d_req = 1'b1; d_addr = AW'(32'h48);
    tick(0);
    d_req = 1'b0;
    rst = 1'b1;
    tick(1);
    check("or_rst_no_rsp", 64'({s_frv, s_drv}), 64'(0));
    exp_q.delete();
    rst = 1'b0;
    check("or_err_in_rst", 64'(err_orphan), 64'(0));
    for (int i = 0; i < 2; i++) begin
      tick(1);
      check("or_no_rsp", 64'({s_frv, s_drv}), 64'(0));
      check("or_err_set", 64'(err_orphan), 64'(1));
    end
    repeat (2) tick(0);
    check("or_err_sticky", 64'(err_orphan), 64'(1));
    check_drained("or_drained");
    rst = 1'b1;
    tick(0);
    rst = 1'b0;
    check("or_err_clr", 64'(err_orphan), 64'(0));

`ifdef MEM_RD_ARB_PERF_CNT_EN
    // Perf counters: 10 contention cycles then a stall burst
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      f_req = 1'b1; f_addr = AW'(32'h600);
      d_req = 1'b1; d_addr = AW'(32'h700 + dn);
      tick(1);
      if (s_dg) dn++;
    end
    f_req = 1'b0; d_req = 1'b0;
    tick(1);
    check("pf_sum", 64'(perf_f_grants + perf_d_grants), 64'(10));
    check("pf_f", 64'(perf_f_grants), 64'(1));
    check("pf_stall0", 64'(perf_full_stalls), 64'(0));
    d_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d_addr = AW'(32'h500 + ((i < 4) ? i : 4));
      tick(0);
    end
    check("pf_d", 64'(perf_d_grants), 64'(13));
    check("pf_stall2", 64'(perf_full_stalls), 64'(2));
    d_req = 1'b0;
    repeat (5) tick(1);
    check_drained("pf_drained");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
